muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Unified, parametrised iterative multiply/divide engine that replaces the separate signed/unsigned multiplier and divider instances in the multi-cycle CPU.
- Performs MULT, MULTU, DIV and DIVU at one bit per cycle over a start/busy/done handshake, and writes results to internal HI/LO result registers.
- Adds a `cancel` input for exception or eret flush, and explicit divide-by-zero reporting.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the product is 2*WIDTH bits.
- CW, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (Rs).
- b  in  WIDTH  multiplier / divisor (Rt).
- cancel  in  1  synchronous abort of an in-flight operation.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo are updated.
- div_by_zero  out  1  pulses with done when DIV/DIVU had b==0.
- hi  out  WIDTH  product[2W-1:W] or remainder.
- lo  out  WIDTH  product[W-1:0] or quotient.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and datapath registers cleared. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1 and cancel=0: latch op, |a|, |b| (magnitudes for signed ops, raw values for unsigned), sign_a, sign_b.
  - Same edge: counter=WIDTH, busy=1, next state CALC.
  - start=0, or start=1 with cancel=1: remain in IDLE.
- CALC:
  - One iteration per cycle; counter decrements each edge. After WIDTH iterations (counter reaches 0), go to FIX.
  - Multiply: shift-add over a 2W-bit accumulator.
  - Divide: restoring divide. Shift {rem,quo} left 1; trial-subtract the divisor from rem; on no borrow keep the difference and set the quotient LSB to 1.
- FIX (one cycle):
  - Sign-correct the result, write hi/lo, and assert done=1 for exactly the following cycle.
  - Same edge: busy=0, return to IDLE.
- Latency: start edge to done-high is exactly WIDTH+2 edges (34 for WIDTH=32), fixed for all ops and operand values.
- Operand inputs (a, b, op) are ignored after the start edge; the engine never reads them mid-operation.
- start while busy=1: ignored; not queued.
- Signed rules:
  - MULT: product negated when sign_a^sign_b.
  - DIV: quotient negated when sign_a^sign_b; remainder takes the sign of the dividend (truncating division).
- Overflow: DIV of most-negative by -1 yields lo=most-negative (0x80000000 for W=32), hi=0, with no flag.
- Divide by zero (b==0, DIV or DIVU):
  - Same latency as a normal divide; hi=a (original, unmodified), lo=all ones.
  - div_by_zero=1 in the same cycle as done.
- cancel=1 in CALC or FIX: next edge goes to IDLE with busy=0, no done pulse, and hi/lo keep their previous values. cancel has priority over FIX completion.
- hi/lo hold their value between operations and change only on the edge that raises done.
- done and div_by_zero are 0 in every cycle except the completion cycle.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE); the new operation begins on that edge.

Test Plan:
- Reset: assert rstn=0 mid-MULT (counter=10) -> busy=0, done=0, hi=lo=0 immediately; no done pulse after release.
- MULT with W=32, a=0xFFFFFFFD (-3), b=7 -> done exactly 34 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU on the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV with a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with a=7, b=2 -> lo=3, hi=1. DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU with a=0x12345678, b=0 -> after 34 edges: done=1, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF.
- Cancel: start a DIV and assert cancel on iteration 5 -> busy falls next edge, no done pulse, hi/lo keep their prior values. A start asserted while busy is ignored; changing a/b mid-operation does not alter the result.
- Parameter sweep with W=8: random MULT/MULTU/DIV/DIVU checked against a reference model over 10k vectors, latency = 10 edges each; also back-to-back start in the done cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: MULT, MULTU, DIV, DIVU at one bit per cycle.
// Results land in hi/lo; done pulses for one cycle when they are written.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;    // multiply: {partial product, multiplier}; divide: {rem, quo}
  logic [WIDTH-1:0]  b_q, b_d;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes at capture time; unsigned ops take the raw value.
  logic             is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add step; the carry out of the add becomes the new MSB after the shift.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step: shift, trial subtract, keep the difference on no borrow.
  logic [W2:0]     div_sh;
  logic [WIDTH:0]  div_trial;
  logic [W2-1:0]   div_next;
  assign div_sh    = {acc_q, 1'b0};
  assign div_trial = div_sh[W2:WIDTH] - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH] ? div_sh[W2-1:0]
                                      : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

  // Sign correction; remainder follows the dividend's sign (truncating division).
  logic             neg_res;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign neg_res  = sign_a_q ^ sign_b_q;
  assign prod_fix = neg_res ? -acc_q : acc_q;
  assign quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          is_div_d = op[1];
          sign_a_d = is_signed & a[WIDTH-1];
          sign_b_d = is_signed & b[WIDTH-1];
          dz_d     = op[1] && (b == '0);
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          b_d      = mag_b;
          cnt_d    = CW'(WIDTH);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // With a zero divisor the remainder path already reproduces a.
            hi_d  = rem_fix;
            lo_d  = dz_q ? '1 : quo_fix;
            dbz_d = dz_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
